// File: rtl/rtmc_mc_multi_pkg.sv
// Shared definitions for the multi-channel stepper sequencer: register map,
// CTRL layout and the half-step phase rules.
package rtmc_pkg;

  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_PERIOD  = 2'd1;
  localparam logic [1:0] OFF_STEPS   = 2'd2;
  localparam logic [1:0] OFF_POS     = 2'd3;
  localparam logic [7:0] STATUS_ADDR = 8'hFF;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_DIR  = 1;
  localparam int CTRL_HALF = 2;
  localparam int CTRL_OE   = 3;

  typedef struct packed {
    logic oe;
    logic half;
    logic dir;
    logic en;
  } ctrl_t;

  function automatic logic [3:0] phase_to_coils(input logic [2:0] idx);
    logic [3:0] coils;
    case (idx)
      3'd0:    coils = 4'b0001;
      3'd1:    coils = 4'b0011;
      3'd2:    coils = 4'b0010;
      3'd3:    coils = 4'b0110;
      3'd4:    coils = 4'b0100;
      3'd5:    coils = 4'b1100;
      3'd6:    coils = 4'b1000;
      3'd7:    coils = 4'b1001;
      default: coils = 4'b0000;
    endcase
    return coils;
  endfunction

  // Full-step mode lives on the odd (two-coil) indices; an even index first aligns by one.
  function automatic logic [2:0] phase_step(input logic [2:0] idx, input logic dir,
                                            input logic half);
    logic [2:0] delta;
    if (!half && idx[0]) begin
      delta = 3'd2;
    end else begin
      delta = 3'd1;
    end
    if (dir) begin
      return idx + delta;
    end else begin
      return idx - delta;
    end
  endfunction

endpackage

// File: rtl/rtmc_mc_multi_if.sv
// Register bus and coil pad bundle of the multi-channel stepper sequencer.
interface rtmc_mc_multi_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
);
  logic [ADDR_W-1:0]   reg_addr;
  logic [DATA_W-1:0]   reg_wdat;
  logic                reg_wr;
  logic                reg_rd;
  logic [DATA_W-1:0]   reg_rdat;
  logic                reg_ack;
  logic [4*NUM_CH-1:0] mc;
  logic [4*NUM_CH-1:0] mc_oe;
  logic                irq;

  modport master (
    output reg_addr, reg_wdat, reg_wr, reg_rd,
    input  reg_rdat, reg_ack, mc, mc_oe, irq
  );

  modport slave (
    input  reg_addr, reg_wdat, reg_wr, reg_rd,
    output reg_rdat, reg_ack, mc, mc_oe, irq
  );
endinterface

// File: rtl/rtmc_mc_multi_chan.sv
// One stepper channel: CTRL/PERIOD/remaining/POS registers, period timer,
// phase sequencer, sticky done flag and registered coil drive.
module rtmc_mc_chan
  import rtmc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_ctrl_i,
  input  logic              wr_period_i,
  input  logic              wr_steps_i,
  input  logic              wr_pos_i,
  input  logic              clr_done_i,
  input  logic [DATA_W-1:0] wdat_i,
  input  logic [1:0]        offset_i,
  output logic [DATA_W-1:0] rdat_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              done_d_o,
  output logic [3:0]        mc_o,
  output logic [3:0]        mc_oe_o
);

  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] period_q, period_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] pos_q, pos_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [2:0]        phase_q, phase_d;
  logic              done_q, done_d;
  logic [3:0]        mc_q, mc_oe_q;
  logic              active_s, step_s, done_set_s;
  logic [2:0]        nxt_phase_s;
  logic [DATA_W-1:0] nxt_pos_s, pos_wr_s;

  assign active_s    = ctrl_q.en && (rem_q != '0);
  assign step_s      = active_s && (cnt_q == '0);
  assign nxt_phase_s = phase_step(phase_q, ctrl_q.dir, ctrl_q.half);
  assign nxt_pos_s   = ctrl_q.dir ? pos_q + DATA_W'(1) : pos_q - DATA_W'(1);
  // A POS write overrides whatever the step would have done to the position.
  assign pos_wr_s    = wr_pos_i ? wdat_i : pos_q;

  always_comb begin
    ctrl_d     = wr_ctrl_i ? ctrl_t'(wdat_i[3:0]) : ctrl_q;
    period_d   = wr_period_i ? wdat_i : period_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    pos_d      = pos_wr_s;
    done_set_s = 1'b0;
    if (wr_ctrl_i && !wdat_i[CTRL_EN]) begin
      rem_d = '0;
    end else if (wr_steps_i) begin
      rem_d      = wdat_i;
      cnt_d      = period_q;
      phase_d    = step_s ? nxt_phase_s : phase_q;
      pos_d      = step_s ? nxt_pos_s : pos_q;
      done_set_s = step_s && (rem_q == DATA_W'(1));
    end else if (step_s) begin
      rem_d      = rem_q - DATA_W'(1);
      cnt_d      = period_q;
      phase_d    = nxt_phase_s;
      pos_d      = wr_pos_i ? wdat_i : nxt_pos_s;
      done_set_s = (rem_q == DATA_W'(1));
    end else if (active_s) begin
      cnt_d = cnt_q - DATA_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    done_d = done_set_s | (done_q & ~clr_done_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      period_q <= '0;
      rem_q    <= '0;
      pos_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= 3'd0;
      done_q   <= 1'b0;
      mc_q     <= 4'h0;
      mc_oe_q  <= 4'h0;
    end else begin
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      rem_q    <= rem_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      done_q   <= done_d;
      mc_q     <= ctrl_q.oe ? phase_to_coils(phase_q) : 4'h0;
      mc_oe_q  <= ctrl_q.oe ? 4'hF : 4'h0;
    end
  end

  always_comb begin
    case (offset_i)
      OFF_CTRL:   rdat_o = DATA_W'(ctrl_q);
      OFF_PERIOD: rdat_o = period_q;
      OFF_STEPS:  rdat_o = rem_q;
      OFF_POS:    rdat_o = pos_q;
      default:    rdat_o = '0;
    endcase
  end

  assign busy_o   = (rem_q != '0);
  assign done_o   = done_q;
  assign done_d_o = done_d;
  assign mc_o     = mc_q;
  assign mc_oe_o  = mc_oe_q;

endmodule

// File: rtl/rtmc_mc_multi.sv
// Multi-channel stepper sequencer top: address decode, STATUS register,
// read data/ack registers and the irq summary over NUM_CH channels.
module rtmc_mc_multi
  import rtmc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
) (
  input logic            clk,
  input logic            rst,
  rtmc_mc_multi_if.slave reg_if
);

  localparam int IDX_W = ADDR_W - 2;

  logic                wr_s, rd_s, is_status_s;
  logic [NUM_CH-1:0]   sel_s, busy_s, done_s, done_d_s, clr_s;
  logic [DATA_W-1:0]   chan_rdat_s [NUM_CH];
  logic [DATA_W-1:0]   status_s, rd_val_s, chan_acc_s;
  logic [2*NUM_CH-1:0] stat_wide_s;
  logic [4*NUM_CH-1:0] mc_s, mc_oe_s;
  logic [DATA_W-1:0]   rdat_q;
  logic                ack_q, irq_q;

  // A simultaneous read and write is handled purely as a write.
  assign wr_s        = reg_if.reg_wr;
  assign rd_s        = reg_if.reg_rd & ~reg_if.reg_wr;
  assign is_status_s = (reg_if.reg_addr == ADDR_W'(STATUS_ADDR));
  assign clr_s       = (wr_s && is_status_s) ? NUM_CH'(reg_if.reg_wdat >> NUM_CH) : '0;
  assign stat_wide_s = {done_s, busy_s};
  assign status_s    = DATA_W'(stat_wide_s);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign sel_s[c] = !is_status_s && (reg_if.reg_addr[ADDR_W-1:2] == IDX_W'(c));
    rtmc_mc_chan #(.DATA_W(DATA_W)) u_chan (
      .clk         (clk),
      .rst         (rst),
      .wr_ctrl_i   (wr_s && sel_s[c] && (reg_if.reg_addr[1:0] == OFF_CTRL)),
      .wr_period_i (wr_s && sel_s[c] && (reg_if.reg_addr[1:0] == OFF_PERIOD)),
      .wr_steps_i  (wr_s && sel_s[c] && (reg_if.reg_addr[1:0] == OFF_STEPS)),
      .wr_pos_i    (wr_s && sel_s[c] && (reg_if.reg_addr[1:0] == OFF_POS)),
      .clr_done_i  (clr_s[c]),
      .wdat_i      (reg_if.reg_wdat),
      .offset_i    (reg_if.reg_addr[1:0]),
      .rdat_o      (chan_rdat_s[c]),
      .busy_o      (busy_s[c]),
      .done_o      (done_s[c]),
      .done_d_o    (done_d_s[c]),
      .mc_o        (mc_s[4*c +: 4]),
      .mc_oe_o     (mc_oe_s[4*c +: 4])
    );
  end

  always_comb begin
    chan_acc_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      chan_acc_s = chan_acc_s | (chan_rdat_s[c] & {DATA_W{sel_s[c]}});
    end
    if (is_status_s) begin
      rd_val_s = status_s;
    end else begin
      rd_val_s = chan_acc_s;
    end
  end

  // irq tracks the next done state so it lines up with the done flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdat_q <= '0;
      ack_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ack_q <= wr_s | rd_s;
      irq_q <= |done_d_s;
      if (wr_s) begin
        rdat_q <= '0;
      end else if (rd_s) begin
        rdat_q <= rd_val_s;
      end
    end
  end

  assign reg_if.reg_rdat = rdat_q;
  assign reg_if.reg_ack  = ack_q;
  assign reg_if.irq      = irq_q;
  assign reg_if.mc       = mc_s;
  assign reg_if.mc_oe    = mc_oe_s;

endmodule
